irq_arbiter: RTL

//  Collects the CPU's hardware interrupt sources (timers, external interrupt pin) into a single

---
 rtl/irq_arbiter_if.sv | 35 +++
 rtl/irq_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/irq_arbiter_if.sv
// irq_arbiter_if
//   Bundles the memory-mapped register bus and the CP0 request/acknowledge
//   signals of the interrupt arbiter.
//   Ports (signals):
//     bus_addr  [31:0]    data-bus byte address
//     bus_we              write strobe, one cycle per write
//     bus_wdata [31:0]    write data
//     bus_rdata [31:0]    read data from the register window (0 outside it)
//     hw_int    [NSRC-1:0] one-hot request to CP0
//     irq_valid           OR of hw_int
//     irq_id    [2:0]     index of the granted source
//     int_ack             one-cycle pulse from CP0 when it takes the interrupt
//   Modports: master = bus / CP0 side, slave = arbiter side.
interface irq_arbiter_if #(
  parameter int NSRC = 6
);
  logic [31:0]     bus_addr;
  logic            bus_we;
  logic [31:0]     bus_wdata;
  logic [31:0]     bus_rdata;
  logic [NSRC-1:0] hw_int;
  logic            irq_valid;
  logic [2:0]      irq_id;
  logic            int_ack;

  modport master (
    output bus_addr, bus_we, bus_wdata, int_ack,
    input  bus_rdata, hw_int, irq_valid, irq_id
  );

  modport slave (
    input  bus_addr, bus_we, bus_wdata, int_ack,
    output bus_rdata, hw_int, irq_valid, irq_id
  );
endinterface

// File: rtl/irq_arbiter.sv
// irq_arbiter
//   Latches interrupt sources into PEND, masks them with MASK, and presents
//   the highest-priority (lowest index) enabled pending source to CP0. One
//   interrupt is held in service from int_ack until the handler writes EOI.
//   Register window at BASE_ADDR: +0x0 PEND (RO, W1C), +0x4 MASK (RW),
//   +0x8 CUR {busy, irq_id} (RO), +0xC EOI (WO).
//   Ports:
//     clk      clock, all state on posedge
//     reset    synchronous, active-low
//     irq_src  raw interrupt lines, synchronous to clk
//     bus      irq_arbiter_if.slave: register bus plus CP0 request/ack
module irq_arbiter #(
  parameter int              NSRC      = 6,
  parameter logic [31:0]     BASE_ADDR = 32'h0000_7F20,
  parameter logic [NSRC-1:0] EDGE_MASK = 6'b000100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  irq_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, REQ, INSERV} state_t;

  state_t          state_reg, state_next;
  logic [NSRC-1:0] pend_reg, pend_next;
  logic [NSRC-1:0] mask_reg, mask_next;
  logic [NSRC-1:0] prev_reg;
  logic [NSRC-1:0] hw_int_reg, hw_int_next;
  logic            valid_reg, valid_next;
  logic [2:0]      id_reg, id_next;

  logic [NSRC-1:0] set_bits;
  logic [NSRC-1:0] w1c_bits;
  logic [NSRC-1:0] ack_bits;
  logic            in_window;
  logic [1:0]      offset;
  logic            wr_pend, wr_mask, wr_eoi;
  logic            cand_found;
  logic [2:0]      cand_id;
  logic            still_live;
  logic            unused_wdata;

  // Only aligned word accesses inside the 16-byte window hit a register.
  assign in_window = (bus.bus_addr[31:4] == BASE_ADDR[31:4]) && (bus.bus_addr[1:0] == 2'b00);
  assign offset    = bus.bus_addr[3:2];
  assign wr_pend   = bus.bus_we && in_window && (offset == 2'd0);
  assign wr_mask   = bus.bus_we && in_window && (offset == 2'd1);
  assign wr_eoi    = bus.bus_we && in_window && (offset == 2'd3);

  assign unused_wdata = ^bus.bus_wdata[31:NSRC];

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_set
      if (EDGE_MASK[gi]) begin : g_edge
        assign set_bits[gi] = irq_src[gi] & ~prev_reg[gi];
      end else begin : g_level
        assign set_bits[gi] = irq_src[gi];
      end
    end
  endgenerate

  assign w1c_bits = wr_pend ? bus.bus_wdata[NSRC-1:0] : '0;
  // hw_int_reg is exactly the one-hot of the granted id while in REQ.
  assign ack_bits = ((state_reg == REQ) && bus.int_ack) ? hw_int_reg : '0;

  // New sets take priority over both software clear and ack clear.
  assign pend_next = (pend_reg & ~w1c_bits & ~ack_bits) | set_bits;
  assign mask_next = wr_mask ? bus.bus_wdata[NSRC-1:0] : mask_reg;

  // Request stays alive only while its PEND and MASK bits survive this cycle.
  assign still_live = |(pend_next & mask_next & hw_int_reg);

  always_comb begin
    cand_found = 1'b0;
    cand_id    = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pend_reg[i] && mask_reg[i]) begin
        cand_found = 1'b1;
        cand_id    = 3'(i);
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    id_next     = id_reg;
    hw_int_next = hw_int_reg;
    valid_next  = valid_reg;
    case (state_reg)
      IDLE: begin
        if (cand_found) begin
          state_next           = REQ;
          id_next              = cand_id;
          hw_int_next          = '0;
          hw_int_next[cand_id] = 1'b1;
          valid_next           = 1'b1;
        end
      end
      REQ: begin
        if (bus.int_ack) begin
          state_next  = INSERV;
          hw_int_next = '0;
          valid_next  = 1'b0;
        end else if (!still_live) begin
          state_next  = IDLE;
          hw_int_next = '0;
          valid_next  = 1'b0;
        end
      end
      INSERV: begin
        if (wr_eoi) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next  = IDLE;
        hw_int_next = '0;
        valid_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      pend_reg   <= '0;
      mask_reg   <= '0;
      prev_reg   <= '0;
      hw_int_reg <= '0;
      valid_reg  <= 1'b0;
      id_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      pend_reg   <= pend_next;
      mask_reg   <= mask_next;
      prev_reg   <= irq_src;
      hw_int_reg <= hw_int_next;
      valid_reg  <= valid_next;
      id_reg     <= id_next;
    end
  end

  always_comb begin
    bus.bus_rdata = '0;
    if (in_window) begin
      case (offset)
        2'd0:    bus.bus_rdata[NSRC-1:0] = pend_reg;
        2'd1:    bus.bus_rdata[NSRC-1:0] = mask_reg;
        2'd2:    bus.bus_rdata[3:0]      = {state_reg == INSERV, id_reg};
        default: bus.bus_rdata           = '0;
      endcase
    end
  end

  assign bus.hw_int    = hw_int_reg;
  assign bus.irq_valid = valid_reg;
  assign bus.irq_id    = id_reg;

endmodule
